// File: rtl/clock_monitor_pkg.sv
// Shared state encoding and default constants for the clock monitor.
// Latency: none; declarations only, no flow control.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    LOST
  } mon_state_e;

  localparam int unsigned DEF_CNT_W   = 32;
  localparam logic [31:0] DEF_TIMEOUT = 32'd200000000;
  localparam int unsigned DUTY_TOL    = 2;

endpackage

// File: rtl/clock_monitor_sync_edge_detect.sv
// Synchroniser plus registered rise/fall pulse detector for an async 1-bit input.
// Latency: SYNC_STAGES+1 clocks to the pulse; no backpressure, pulses are dropped while enable_i is low.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // The chain and previous-value flop keep running while disabled so that
  // re-enabling never reports a stale edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= s;
      rise_o <= enable_i & s & ~prev_q;
      fall_o <= enable_i & ~s & prev_q;
    end
  end

endmodule

// File: rtl/clock_monitor.sv
// Measures period/high time of a slow async clock and flags its loss; CLOCK_MONITOR_DUTY_EN adds high-time capture and duty_err_o.
// Latency: edge pulses 3 clocks after the input transition, results one clock after the pulse; no backpressure.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(DEF_TIMEOUT)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             mon_clk_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             period_upd_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             lost_o
`ifdef CLOCK_MONITOR_DUTY_EN
  ,
  output logic             duty_err_o
`endif
);

  mon_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             rise, fall;
  logic             measuring;
  logic             timeout_hit;
  logic             period_take;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .enable_i(enable_i),
    .d_i     (mon_clk_i),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  assign rise_o = rise;
  assign fall_o = fall;

  // Saturating increment; also the measured length when an edge lands this cycle.
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign measuring   = (state_q == ARM) || (state_q == MEAS);
  assign timeout_hit = measuring && !rise && (cnt_inc == TIMEOUT);
  assign period_take = enable_i && measuring && rise;

  always_comb begin
    state_nxt = state_q;
    if (!enable_i) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEAS;
                 else if (timeout_hit) state_nxt = LOST;
        MEAS:    if (timeout_hit) state_nxt = LOST;
        LOST:    if (rise) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      period_upd_o   <= 1'b0;
      lost_o         <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      cnt_q          <= (state_q == IDLE || rise) ? '0 : cnt_inc;
      period_valid_o <= (state_nxt == MEAS);
      lost_o         <= (state_nxt == LOST);
      period_upd_o   <= period_take;
      if (period_take) period_o <= cnt_inc;
    end
  end

`ifdef CLOCK_MONITOR_DUTY_EN
  logic [CNT_W-1:0] high_q;
  logic [CNT_W+1:0] two_high, per_ext, duty_diff;
  logic             duty_bad;

  // Compare against the period being captured this cycle, with the high
  // time from the fall that preceded it.
  assign two_high  = {1'b0, high_q, 1'b0};
  assign per_ext   = {2'b00, cnt_inc};
  assign duty_diff = (two_high > per_ext) ? two_high - per_ext : per_ext - two_high;
  assign duty_bad  = duty_diff > (CNT_W+2)'(DUTY_TOL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      high_q     <= '0;
      duty_err_o <= 1'b0;
    end else begin
      if (enable_i && measuring && fall) high_q <= cnt_inc;
      if (!enable_i)        duty_err_o <= 1'b0;
      else if (period_take) duty_err_o <= duty_bad;
    end
  end

  assign high_time_o = high_q;
`else
  assign high_time_o = '0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: latency, period/high time, loss, enable drop and async reset.
module tb_clock_monitor;

  localparam int CNT_W = 16;
  localparam int TO    = 32;
`ifdef CLOCK_MONITOR_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clock     = 1'b0;
  logic             reset_n   = 1'b0;
  logic             enable_i  = 1'b1;
  logic             mon_clk_i = 1'b0;
  logic             rise_o, fall_o, period_valid_o, period_upd_o, lost_o;
  logic [CNT_W-1:0] period_o, high_time_o;
`ifdef CLOCK_MONITOR_DUTY_EN
  logic             duty_err_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_upd  = 0;

  always #5 clock = ~clock;

  clock_monitor #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .TIMEOUT    (CNT_W'(TO))
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable_i      (enable_i),
    .mon_clk_i     (mon_clk_i),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .period_o      (period_o),
    .period_valid_o(period_valid_o),
    .period_upd_o  (period_upd_o),
    .high_time_o   (high_time_o),
    .lost_o        (lost_o)
`ifdef CLOCK_MONITOR_DUTY_EN
    ,
    .duty_err_o    (duty_err_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Drive mon_clk_i for n clocks; outputs are observed 1ns after each edge.
  task automatic cycles(input logic m, input int n);
    for (int i = 0; i < n; i++) begin
      mon_clk_i = m;
      @(posedge clock);
      #1;
      if (period_upd_o) n_upd++;
    end
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_rise"},   rise_o, 0);
    chk({p, "_fall"},   fall_o, 0);
    chk({p, "_period"}, period_o, 0);
    chk({p, "_valid"},  period_valid_o, 0);
    chk({p, "_upd"},    period_upd_o, 0);
    chk({p, "_high"},   high_time_o, 0);
    chk({p, "_lost"},   lost_o, 0);
`ifdef CLOCK_MONITOR_DUTY_EN
    chk({p, "_duty"},   duty_err_o, 0);
`endif
  endtask

  // Starting in IDLE with mon low: 5 high / 5 low, then the second rise.
  task automatic basic_run(input string p);
    cycles(1, 2); chk({p, "_rise_early"}, rise_o, 0);
    cycles(1, 1); chk({p, "_rise_lat3"}, rise_o, 1);
    cycles(1, 2);
    cycles(0, 3); chk({p, "_fall"}, fall_o, 1);
    cycles(0, 1); chk({p, "_high5"}, high_time_o, DUTY ? 5 : 0);
    cycles(0, 1);
    cycles(1, 3); chk({p, "_rise2"}, rise_o, 1);
                  chk({p, "_valid_arm"}, period_valid_o, 0);
    cycles(1, 1); chk({p, "_upd"}, period_upd_o, 1);
                  chk({p, "_period10"}, period_o, 10);
                  chk({p, "_valid"}, period_valid_o, 1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    cycles(0, 4);

    // Scenario 1: 5/5 from IDLE
    basic_run("s1");
    cycles(1, 1); chk("s1_upd_pulse", period_upd_o, 0);

    // Scenario 2: two periods 3/7, then two periods 5/5
    cycles(0, 5);
    cycles(1, 3); cycles(0, 7); cycles(1, 3); cycles(0, 7);
    chk("s2_period", period_o, 10);
    chk("s2_high3", high_time_o, DUTY ? 3 : 0);
`ifdef CLOCK_MONITOR_DUTY_EN
    chk("s2_duty_err", duty_err_o, 1);
`endif
    cycles(1, 5); cycles(0, 5); cycles(1, 5); cycles(0, 5);
    chk("s2_period_55", period_o, 10);
    chk("s2_high5", high_time_o, DUTY ? 5 : 0);
`ifdef CLOCK_MONITOR_DUTY_EN
    chk("s2_duty_ok", duty_err_o, 0);
`endif

    // Scenario 3: last rise_o seen 53 edges in; loss shows TO+1 edges later
    cycles(0, 25); chk("s3_lost_early", lost_o, 0);
    cycles(0, 1);  chk("s3_lost", lost_o, 1);
                   chk("s3_valid", period_valid_o, 0);
                   chk("s3_period_hold", period_o, 10);
    cycles(1, 3);  chk("s3_rise", rise_o, 1);
                   chk("s3_lost_still", lost_o, 1);
    cycles(1, 1);  chk("s3_lost_clr", lost_o, 0);
                   chk("s3_valid_arm", period_valid_o, 0);
    cycles(1, 1); cycles(0, 5);
    cycles(1, 3);
    cycles(1, 1);  chk("s3_upd", period_upd_o, 1);
                   chk("s3_valid_again", period_valid_o, 1);
                   chk("s3_period", period_o, 10);

    // Scenario 4: rise exactly at the timeout count
    cycles(1, 1); cycles(0, 27);
    cycles(1, 3);  chk("s4_rise", rise_o, 1);
                   chk("s4_no_lost_rise", lost_o, 0);
    cycles(1, 1);  chk("s4_upd", period_upd_o, 1);
                   chk("s4_period32", period_o, TO);
                   chk("s4_no_lost", lost_o, 0);
                   chk("s4_valid", period_valid_o, 1);

    // Scenario 5: a period of 9, then enable low for one clock
    cycles(1, 1); cycles(0, 4);
    cycles(1, 5); cycles(0, 5);
    enable_i = 1'b0;
    cycles(0, 1);  chk("s5_valid", period_valid_o, 0);
                   chk("s5_period_hold", period_o, 9);
                   chk("s5_upd", period_upd_o, 0);
    enable_i = 1'b1;
    n_upd = 0;
    cycles(1, 5); cycles(0, 5);
    chk("s5_no_upd_first_rise", n_upd, 0);
    cycles(1, 5);
    chk("s5_upd_second_rise", n_upd, 1);
    chk("s5_period", period_o, 10);
    chk("s5_valid_again", period_valid_o, 1);

    // Scenario 6: async reset between edges, then the basic run again
    cycles(0, 3);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("s6_rst");
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    cycles(0, 3);
    basic_run("s6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
